rvv_result_collector: RTL and testbench



---
 rtl/rvv_pkg.sv | 24 ++
 rtl/rvv_lane_merge.sv | 56 +++++
 rtl/rvv_result_collector.sv | 109 ++++++++++
 tb/tb_rvv_result_collector.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rvv_pkg.sv
// Shared RVV datapath definitions: collector state encoding, SEW and operand-type
// constants, and the element-width helper.
package rvv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WB      = 2'd2
    } collect_state_t;

    localparam logic [2:0] SEW_8  = 3'd0;
    localparam logic [2:0] SEW_16 = 3'd1;
    localparam logic [2:0] SEW_32 = 3'd2;
    localparam logic [2:0] SEW_64 = 3'd3;

    localparam logic [1:0] OP_VV = 2'd0;
    localparam logic [1:0] OP_VX = 2'd1;
    localparam logic [1:0] OP_VI = 2'd2;

    function automatic logic [6:0] elem_bits(input logic [2:0] vsew);
        return 7'd8 << vsew;
    endfunction

endpackage

// File: rtl/rvv_lane_merge.sv
// Per-lane write-enable/data expansion into VLEN-wide vectors, with tail
// limiting, out-of-range dropping and mask-op single-bit placement.
module rvv_lane_merge
    import rvv_pkg::*;
#(
    parameter int VLEN       = 128,
    parameter int LANE_WIDTH = 3,
    parameter int NB_LANES   = 1
) (
    input  logic [(64<<NB_LANES)-1:0]             lane_vd,
    input  logic [(10<<NB_LANES)-1:0]             lane_idx,
    input  logic [(1<<NB_LANES)-1:0]              lane_valid,
    input  logic [13:0]                           tail_limit,
    input  logic                                  instr_mask,
    output logic [(1<<NB_LANES)-1:0][VLEN-1:0]    lane_we,
    output logic [(1<<NB_LANES)-1:0][VLEN-1:0]    lane_data
);
    localparam int C  = 1 << LANE_WIDTH;
    localparam int NL = 1 << NB_LANES;

    // Bits at or above tail_limit keep the old destination value.
    logic [VLEN-1:0] tail_mask;
    assign tail_mask = ~({VLEN{1'b1}} << tail_limit);

    genvar gi;
    generate
        for (gi = 0; gi < NL; gi++) begin : g_lane
            logic [C-1:0] chunk;
            logic [9:0]   idx;
            logic         chunk_fits;
            logic         bit_fits;

            assign chunk      = lane_vd[gi*64 +: C];
            assign idx        = lane_idx[gi*10 +: 10];
            assign chunk_fits = ({1'b0, idx} + 11'(C)) <= 11'(VLEN);
            assign bit_fits   = ({1'b0, idx} < 11'(VLEN)) && ({4'd0, idx} < tail_limit);

            always_comb begin
                lane_we[gi]   = '0;
                lane_data[gi] = '0;
                if (lane_valid[gi]) begin
                    if (instr_mask) begin
                        if (bit_fits) begin
                            lane_we[gi]   = VLEN'(1) << idx;
                            lane_data[gi] = VLEN'(chunk[0]) << idx;
                        end
                    end else if (chunk_fits) begin
                        lane_we[gi]   = (VLEN'({C{1'b1}}) << idx) & tail_mask;
                        lane_data[gi] = VLEN'(chunk) << idx;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/rvv_result_collector.sv
// Assembles the lane result stream into one VLEN destination value and hands it
// to VRF writeback over a valid/ready handshake.
module rvv_result_collector
    import rvv_pkg::*;
#(
    parameter int VLEN       = 128,
    parameter int LANE_WIDTH = 3,
    parameter int NB_LANES   = 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    input  logic [2:0]                   vsew,
    input  logic [10:0]                  vl,
    input  logic                         instr_mask,
    input  logic [VLEN-1:0]              vd_old,
    input  logic [(64<<NB_LANES)-1:0]    lane_vd,
    input  logic [(10<<NB_LANES)-1:0]    lane_idx,
    input  logic [(1<<NB_LANES)-1:0]     lane_valid,
    input  logic                         alu_done,
    output logic [VLEN-1:0]              vd_out,
    output logic                         wb_valid,
    input  logic                         wb_ready,
    output logic                         busy
);
    localparam int NL = 1 << NB_LANES;

    collect_state_t               state;
    logic [VLEN-1:0]              acc;
    logic [13:0]                  limit_reg;
    logic                         mask_reg;
    logic [NL-1:0][VLEN-1:0]      lane_we;
    logic [NL-1:0][VLEN-1:0]      lane_data;
    logic [VLEN-1:0]              acc_next;
    logic [17:0]                  tail_bits;
    logic [13:0]                  limit_next;

    // Normal ops limit by element bits (saturated to VLEN); mask ops by element count.
    assign tail_bits  = 18'(vl) * 18'(elem_bits(vsew));
    assign limit_next = instr_mask ? 14'(vl)
                      : (tail_bits >= 18'(VLEN)) ? 14'(VLEN) : tail_bits[13:0];

    rvv_lane_merge #(
        .VLEN       (VLEN),
        .LANE_WIDTH (LANE_WIDTH),
        .NB_LANES   (NB_LANES)
    ) u_merge (
        .lane_vd    (lane_vd),
        .lane_idx   (lane_idx),
        .lane_valid (lane_valid),
        .tail_limit (limit_reg),
        .instr_mask (mask_reg),
        .lane_we    (lane_we),
        .lane_data  (lane_data)
    );

    // Fold in ascending lane order so the highest lane wins on overlap.
    always_comb begin
        acc_next = acc;
        for (int i = 0; i < NL; i++) begin
            acc_next = (acc_next & ~lane_we[i]) | (lane_data[i] & lane_we[i]);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            acc       <= '0;
            vd_out    <= '0;
            wb_valid  <= 1'b0;
            busy      <= 1'b0;
            limit_reg <= '0;
            mask_reg  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc       <= vd_old;
                        limit_reg <= limit_next;
                        mask_reg  <= instr_mask;
                        busy      <= 1'b1;
                        state     <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    acc <= acc_next;
                    if (alu_done) begin
                        vd_out   <= acc_next;
                        wb_valid <= 1'b1;
                        state    <= ST_WB;
                    end
                end
                ST_WB: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    wb_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rvv_result_collector.sv
// Directed bench for rvv_result_collector: table of whole operations plus
// hand sequences for handshake stall, lane overlap and mid-collect reset.
module tb_rvv_result_collector;

    localparam int VLEN = 128;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic [2:0]        vsew = '0;
    logic [10:0]       vl = '0;
    logic              instr_mask = 1'b0;
    logic [VLEN-1:0]   vd_old = '0;
    logic [127:0]      lane_vd = '0;
    logic [19:0]       lane_idx = '0;
    logic [1:0]        lane_valid = '0;
    logic              alu_done = 1'b0;
    logic [VLEN-1:0]   vd_out;
    logic              wb_valid;
    logic              wb_ready = 1'b0;
    logic              busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rvv_result_collector #(.VLEN(VLEN), .LANE_WIDTH(3), .NB_LANES(1)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .vsew       (vsew),
        .vl         (vl),
        .instr_mask (instr_mask),
        .vd_old     (vd_old),
        .lane_vd    (lane_vd),
        .lane_idx   (lane_idx),
        .lane_valid (lane_valid),
        .alu_done   (alu_done),
        .vd_out     (vd_out),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .busy       (busy)
    );

    typedef struct {
        string        name;
        logic [2:0]   vsew;
        logic [10:0]  vl;
        logic         mask;
        logic [127:0] vd_old;
        int           mode;   // 0: data=byte index, 1: data=0x00, 3: mask bits idx 0..15
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Upper slot bits carry junk that must never reach the result.
    task automatic set_lanes(input logic [9:0] i0, input logic [7:0] d0,
                             input logic [9:0] i1, input logic [7:0] d1,
                             input logic [1:0] v);
        lane_idx   = {i1, i0};
        lane_vd    = {56'hBADC0FFEE0DDF0, d1, 56'h5A5A5A5A5A5A5A, d0};
        lane_valid = v;
    endtask

    task automatic begin_op(input logic [2:0] s, input logic [10:0] l,
                            input logic m, input logic [127:0] old);
        start = 1'b1; vsew = s; vl = l; instr_mask = m; vd_old = old;
        tick();
        start = 1'b0; vd_old = ~old;
    endtask

    task automatic stream_beats(input int mode, input string nm);
        for (int k = 0; k < 8; k++) begin
            if (mode == 3)
                set_lanes(10'(2*k), 8'h01, 10'(2*k+1), 8'h01, 2'b11);
            else if (mode == 1)
                set_lanes(10'(16*k), 8'h00, 10'(16*k+8), 8'h00, 2'b11);
            else
                set_lanes(10'(16*k), 8'(2*k), 10'(16*k+8), 8'(2*k+1), 2'b11);
            alu_done = (k == 7);
            tick();
            if (k == 0) chk({nm, " wb_valid_low_in_collect"}, 128'(wb_valid), 128'(0));
        end
        lane_valid = '0;
        alu_done   = 1'b0;
    endtask

    task automatic handshake(input string nm, input logic [127:0] exp);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        chk({nm, " wb_valid_after_hs"}, 128'(wb_valid), 128'(0));
        chk({nm, " busy_after_hs"}, 128'(busy), 128'(0));
        chk({nm, " vd_out_held_idle"}, vd_out, exp);
    endtask

    initial begin
        vecs[0] = '{"sew8_vl16", 3'd0, 11'd16, 1'b0, 128'h0, 0,
                    128'h0F0E0D0C_0B0A0908_07060504_03020100};
        vecs[1] = '{"sew8_vl5_tail", 3'd0, 11'd5, 1'b0, {128{1'b1}}, 1,
                    128'hFFFFFFFF_FFFFFFFF_FFFFFF00_00000000};
        vecs[2] = '{"sew32_vl3", 3'd2, 11'd3, 1'b0, 128'h11111111_22222222_33333333_44444444, 0,
                    128'h11111111_0B0A0908_07060504_03020100};
        vecs[3] = '{"mask_vl10", 3'd0, 11'd10, 1'b1, 128'hDEADBEEF_CAFEF00D_12345678_9ABCC000, 3,
                    128'hDEADBEEF_CAFEF00D_12345678_9ABCC3FF};
        vecs[4] = '{"vl0", 3'd0, 11'd0, 1'b0, 128'h0123456789ABCDEF_FEDCBA9876543210, 0,
                    128'h0123456789ABCDEF_FEDCBA9876543210};
        vecs[5] = '{"sew16_vl3", 3'd1, 11'd3, 1'b0, {128{1'b1}}, 0,
                    128'hFFFFFFFF_FFFFFFFF_FFFF0504_03020100};
        vecs[6] = '{"sew64_vl100_sat", 3'd3, 11'd100, 1'b0, {128{1'b1}}, 0,
                    128'h0F0E0D0C_0B0A0908_07060504_03020100};

        repeat (2) tick();
        chk("reset vd_out", vd_out, 128'h0);
        chk("reset wb_valid", 128'(wb_valid), 128'(0));
        chk("reset busy", 128'(busy), 128'(0));
        resetn = 1'b1;
        tick();

        for (int v = 0; v < 7; v++) begin
            begin_op(vecs[v].vsew, vecs[v].vl, vecs[v].mask, vecs[v].vd_old);
            chk({vecs[v].name, " busy_collect"}, 128'(busy), 128'(1));
            stream_beats(vecs[v].mode, vecs[v].name);
            chk({vecs[v].name, " wb_valid_rise"}, 128'(wb_valid), 128'(1));
            chk({vecs[v].name, " vd_out"}, vd_out, vecs[v].exp);
            handshake(vecs[v].name, vecs[v].exp);
            $display("op %s vd_out=%h", vecs[v].name, vd_out);
        end

        // Stall in WB: outputs stable, start and lane writes ignored, start at H ignored.
        begin_op(3'd0, 11'd16, 1'b0, 128'h0);
        stream_beats(0, "stall");
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            set_lanes(10'd0, 8'hEE, 10'd8, 8'hEE, 2'b11);
            tick();
            chk("stall wb_valid", 128'(wb_valid), 128'(1));
            chk("stall vd_out", vd_out, vecs[0].exp);
        end
        lane_valid = '0;
        start      = 1'b1;
        vd_old     = 128'h77;
        wb_ready   = 1'b1;
        tick();
        start    = 1'b0;
        wb_ready = 1'b0;
        chk("stall start_at_H busy", 128'(busy), 128'(0));
        chk("stall start_at_H wb_valid", 128'(wb_valid), 128'(0));
        tick();
        chk("stall idle_stays", 128'(busy), 128'(0));
        $display("op stall vd_out=%h", vd_out);

        // Overlap: higher lane wins; chunk crossing VLEN is dropped.
        begin_op(3'd0, 11'd16, 1'b0, 128'h0);
        set_lanes(10'd0, 8'h11, 10'd0, 8'h22, 2'b11);
        tick();
        set_lanes(10'd121, 8'h33, 10'd120, 8'h44, 2'b11);
        alu_done = 1'b1;
        tick();
        lane_valid = '0;
        alu_done   = 1'b0;
        chk("overlap vd_out", vd_out, 128'h44000000_00000000_00000000_00000022);
        handshake("overlap", 128'h44000000_00000000_00000000_00000022);
        $display("op overlap vd_out=%h", vd_out);

        // Reset mid-collect discards the partial result.
        begin_op(3'd0, 11'd16, 1'b0, 128'h0);
        set_lanes(10'd0, 8'hAB, 10'd8, 8'hCD, 2'b11);
        repeat (3) tick();
        resetn = 1'b0;
        #1;
        chk("midreset busy", 128'(busy), 128'(0));
        chk("midreset wb_valid", 128'(wb_valid), 128'(0));
        chk("midreset vd_out", vd_out, 128'h0);
        lane_valid = '0;
        tick();
        resetn = 1'b1;
        tick();
        begin_op(vecs[1].vsew, vecs[1].vl, vecs[1].mask, vecs[1].vd_old);
        stream_beats(vecs[1].mode, "after_reset");
        chk("after_reset wb_valid", 128'(wb_valid), 128'(1));
        chk("after_reset vd_out", vd_out, vecs[1].exp);
        handshake("after_reset", vecs[1].exp);
        $display("op after_reset vd_out=%h", vd_out);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
